// File: rtl/ic_restore_ctrl.sv
// Restore-side controller: drains the show-ahead backup buffer into the register wrappers.
// Optional ack watchdog enabled by defining RCU_TIMEOUT_EN.
module ic_restore_ctrl #(
  parameter int IDX_W       = 5,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 6,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start,
  input  logic                    Abort,
  input  logic                    IsEmpty_Buffer,
  input  logic [IDX_W+DATA_W-1:0] Data_Buffer,
  output logic                    PopEn_Buffer,
  output logic [IDX_W-1:0]        RegIdx,
  output logic [DATA_W-1:0]       RegData,
  output logic                    RestoreEn,
  input  logic                    Restore_Ack,
  output logic [CNT_W-1:0]        RestoreCnt,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Err,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Handshake: an entry is consumed when PopEn_Buffer is high at a clock edge;
  // a write completes when RestoreEn and Restore_Ack are both high at a clock edge.

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pop, ren, done;

`ifdef RCU_TIMEOUT_EN
  localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  logic [TO_W-1:0] tmr_q, tmr_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    ren     = 1'b0;
    done    = 1'b0;
`ifdef RCU_TIMEOUT_EN
    tmr_d   = tmr_q;
    err_d   = err_q;
`endif
    if (state_q == S_ERROR) begin
      // Only reset leaves ERROR; Start and Abort are deliberately ignored here.
      state_d = S_ERROR;
    end else if (Abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_d = S_FETCH;
            cnt_d   = '0;
          end
        end
        S_FETCH: begin
          if (IsEmpty_Buffer) begin
            state_d = S_DONE;
          end else begin
            pop     = 1'b1;
            idx_d   = Data_Buffer[IDX_W+DATA_W-1:DATA_W];
            data_d  = Data_Buffer[DATA_W-1:0];
            state_d = S_WRITE;
`ifdef RCU_TIMEOUT_EN
            tmr_d   = '0;
`endif
          end
        end
        S_WRITE: begin
          ren = 1'b1;
          if (Restore_Ack) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            state_d = S_FETCH;
          end else begin
`ifdef RCU_TIMEOUT_EN
            if (tmr_q == TO_LAST) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end else begin
              tmr_d = tmr_q + 1'b1;
            end
`endif
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef RCU_TIMEOUT_EN
      tmr_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef RCU_TIMEOUT_EN
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`endif
    end
  end

  assign PopEn_Buffer = pop;
  assign RestoreEn    = ren;
  assign Done         = done;
  assign RegIdx       = idx_q;
  assign RegData      = data_q;
  assign RestoreCnt   = cnt_q;
  assign Busy         = (state_q == S_FETCH) || (state_q == S_WRITE);
  assign dbg_state    = state_q;
`ifdef RCU_TIMEOUT_EN
  assign Err          = err_q;
`else
  assign Err          = 1'b0;
`endif

endmodule

// File: tb/tb_ic_restore_ctrl.sv
// Directed bench for ic_restore_ctrl: table-driven main drain plus hand-written corner sequences.
module tb_ic_restore_ctrl;

  localparam int IDX_W  = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic                    is_empty = 1'b1;
  logic [IDX_W+DATA_W-1:0] data_buf = '0;
  logic                    pop_en;
  logic [IDX_W-1:0]        reg_idx;
  logic [DATA_W-1:0]       reg_data;
  logic                    restore_en;
  logic                    restore_ack = 1'b0;
  logic [CNT_W-1:0]        restore_cnt;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [2:0]              dbg_state;

  ic_restore_ctrl #(.IDX_W(IDX_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .ACK_TIMEOUT(16)) dut (
    .Clk(clk), .Rst(rst), .Start(start), .Abort(abort),
    .IsEmpty_Buffer(is_empty), .Data_Buffer(data_buf), .PopEn_Buffer(pop_en),
    .RegIdx(reg_idx), .RegData(reg_data), .RestoreEn(restore_en),
    .Restore_Ack(restore_ack), .RestoreCnt(restore_cnt), .Busy(busy),
    .Done(done), .Err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- buffer model and scoreboard ----------------
  logic [IDX_W+DATA_W-1:0] buf_q[$];
  logic [IDX_W-1:0]        exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [DATA_W-1:0] data_of(input logic [IDX_W-1:0] idx);
    return 32'hC0DE_0000 | {27'd0, idx};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh_buf();
    is_empty = (buf_q.size() == 0);
    data_buf = (buf_q.size() != 0) ? buf_q[0] : '0;
  endtask

  task automatic load(input logic [IDX_W-1:0] idx);
    buf_q.push_back({idx, data_of(idx)});
    refresh_buf();
  endtask

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    logic p;
    p = pop_en;
    @(posedge clk);
    #1;
    if (p && buf_q.size() != 0) void'(buf_q.pop_front());
    refresh_buf();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; restore_ack = 1'b0;
    buf_q.delete();
    refresh_buf();
    settle();
    adv();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pop"},   pop_en, 0);
    chk({tag, "_ren"},   restore_en, 0);
    chk({tag, "_idx"},   reg_idx, 0);
    chk({tag, "_data"},  reg_data, 0);
    chk({tag, "_cnt"},   restore_cnt, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic             start;
    logic             ack;
    logic             exp_pop;
    logic             exp_ren;
    logic [IDX_W-1:0] exp_idx;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_busy;
    logic             exp_done;
    logic [2:0]       exp_state;
  } vec_t;

  vec_t tv[10];

  initial begin
    int  writes;
    bit  stopped;
    int  lim;

    // start, ack, pop, ren, idx, cnt, busy, done, state
    tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  6'd0, 1'b0, 1'b0, ST_IDLE};
    tv[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  6'd0, 1'b1, 1'b0, ST_FETCH};
    tv[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  6'd0, 1'b1, 1'b0, ST_WRITE};
    tv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd3,  6'd1, 1'b1, 1'b0, ST_FETCH};
    tv[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  6'd1, 1'b1, 1'b0, ST_WRITE};
    tv[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd7,  6'd2, 1'b1, 1'b0, ST_FETCH};
    tv[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 6'd2, 1'b1, 1'b0, ST_WRITE};
    tv[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 6'd3, 1'b1, 1'b0, ST_FETCH};
    tv[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 6'd3, 1'b0, 1'b1, ST_DONE};
    tv[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 6'd3, 1'b0, 1'b0, ST_IDLE};

    // --- reset state and empty-buffer restore ---
    do_reset();
    settle();
    chk_zero("rst");
    start = 1'b1;
    adv();
    start = 1'b0;
    settle();
    chk("e_c1_busy", busy, 1);
    chk("e_c1_pop", pop_en, 0);
    chk("e_c1_done", done, 0);
    adv();
    settle();
    chk("e_c2_done", done, 1);
    chk("e_c2_busy", busy, 0);
    chk("e_c2_pop", pop_en, 0);
    adv();
    settle();
    chk("e_c3_done", done, 0);
    chk("e_c3_state", dbg_state, ST_IDLE);
    chk("e_c3_cnt", restore_cnt, 0);

    // --- three entries, ack tied high (table) ---
    do_reset();
    load(5'd3); load(5'd7); load(5'd12);
    exp_q.push_back(5'd3); exp_q.push_back(5'd7); exp_q.push_back(5'd12);
    for (int i = 0; i < 10; i++) begin
      start       = tv[i].start;
      restore_ack = tv[i].ack;
      settle();
      chk($sformatf("t%0d_pop", i),   pop_en, tv[i].exp_pop);
      chk($sformatf("t%0d_ren", i),   restore_en, tv[i].exp_ren);
      chk($sformatf("t%0d_idx", i),   reg_idx, tv[i].exp_idx);
      chk($sformatf("t%0d_cnt", i),   restore_cnt, tv[i].exp_cnt);
      chk($sformatf("t%0d_busy", i),  busy, tv[i].exp_busy);
      chk($sformatf("t%0d_done", i),  done, tv[i].exp_done);
      chk($sformatf("t%0d_state", i), dbg_state, tv[i].exp_state);
      if (tv[i].exp_ren) chk($sformatf("t%0d_data", i), reg_data, data_of(tv[i].exp_idx));
      if (restore_en) begin
        if (exp_q.size() != 0) chk("sb_idx", reg_idx, exp_q.pop_front());
        else chk("sb_unexpected_write", 1, 0);
      end
      adv();
    end
    chk("sb_left", exp_q.size(), 0);
    chk("t_buf_drained", buf_q.size(), 0);

    // --- one entry, ack four cycles after RestoreEn rises ---
    do_reset();
    load(5'd21);
    start = 1'b1;
    adv();
    start = 1'b0;
    settle();
    chk("s3_pop", pop_en, 1);
    adv();
    for (int k = 0; k < 5; k++) begin
      restore_ack = (k == 4);
      settle();
      chk($sformatf("s3_ren%0d", k), restore_en, 1);
      chk($sformatf("s3_idx%0d", k), reg_idx, 5'd21);
      chk($sformatf("s3_data%0d", k), reg_data, data_of(5'd21));
      chk($sformatf("s3_cnt%0d", k), restore_cnt, 0);
      adv();
    end
    restore_ack = 1'b0;
    settle();
    chk("s3_ren_off", restore_en, 0);
    chk("s3_cnt", restore_cnt, 1);
    chk("s3_state", dbg_state, ST_FETCH);
    adv();
    settle();
    chk("s3_done", done, 1);

    // --- abort together with ack in WRITE ---
    do_reset();
    load(5'd9); load(5'd10);
    start = 1'b1;
    adv();
    start = 1'b0;
    settle();
    chk("s4_pop", pop_en, 1);
    adv();
    abort = 1'b1;
    restore_ack = 1'b1;
    settle();
    chk("s4_ren_gated", restore_en, 0);
    chk("s4_state_w", dbg_state, ST_WRITE);
    adv();
    abort = 1'b0;
    restore_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("s4_idle%0d", k), dbg_state, ST_IDLE);
      chk($sformatf("s4_pop%0d", k), pop_en, 0);
      chk($sformatf("s4_done%0d", k), done, 0);
      chk($sformatf("s4_cnt%0d", k), restore_cnt, 0);
      adv();
    end
    chk("s4_buf_left", buf_q.size(), 1);

    // --- ack never arrives ---
    do_reset();
    load(5'd20);
    start = 1'b1;
    adv();
    start = 1'b0;
    settle();
    adv();
    writes = 0;
    stopped = 1'b0;
`ifdef RCU_TIMEOUT_EN
    lim = 40;
`else
    lim = 20;
`endif
    for (int k = 0; k < lim; k++) begin
      settle();
      if (dbg_state != ST_WRITE) begin
        stopped = 1'b1;
        break;
      end
      writes++;
      adv();
    end
    if (!stopped) settle();
`ifdef RCU_TIMEOUT_EN
    chk("s5_writes", writes, 16);
    chk("s5_state", dbg_state, ST_ERROR);
    chk("s5_err", err, 1);
    chk("s5_ren", restore_en, 0);
    chk("s5_busy", busy, 0);
    start = 1'b1;
    adv();
    start = 1'b0;
    abort = 1'b1;
    settle();
    chk("s5_start_ign", dbg_state, ST_ERROR);
    adv();
    abort = 1'b0;
    settle();
    chk("s5_abort_ign", dbg_state, ST_ERROR);
    chk("s5_err_sticky", err, 1);
    chk("s5_pop", pop_en, 0);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    settle();
    chk("s5_err_clr", err, 0);
    chk("s5_idle", dbg_state, ST_IDLE);
`else
    chk("s5_writes", writes, 20);
    chk("s5_state", dbg_state, ST_WRITE);
    chk("s5_ren", restore_en, 1);
    chk("s5_err", err, 0);
`endif

    // --- Start while busy, then reset mid-WRITE ---
    do_reset();
    load(5'd17);
    start = 1'b1;
    adv();
    start = 1'b0;
    settle();
    adv();
    start = 1'b1;
    settle();
    chk("s6_state_w", dbg_state, ST_WRITE);
    chk("s6_busy", busy, 1);
    adv();
    start = 1'b0;
    settle();
    chk("s6_start_ign", dbg_state, ST_WRITE);
    chk("s6_ren", restore_en, 1);
    chk("s6_idx", reg_idx, 5'd17);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    settle();
    chk_zero("s6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
